// File: rtl/input_debounce_if.sv
// Raw-input and debounced-output bundle for input_debounce.
// There is no handshake: btn_raw is sampled asynchronously; outputs are levels and strobes.
interface input_debounce_if #(
    parameter int N = 2
);
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_clean;
    logic [N-1:0] btn_rise;
    logic [N-1:0] btn_fall;

    modport master (output btn_raw, input btn_clean, input btn_rise, input btn_fall);
    modport slave  (input btn_raw, output btn_clean, output btn_rise, output btn_fall);
endinterface

// File: rtl/input_debounce.sv
// Per-channel 2-flop synchronizer plus stability counter; the clean level only
// moves after STABLE_CYCLES consecutive synchronized samples disagree with it.
module input_debounce #(
    parameter int N             = 2,
    parameter int STABLE_CYCLES = 250000
) (
    input logic             clk,
    input logic             rst,
    input_debounce_if.slave bus
);
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [N-1:0]         sync1;
    logic [N-1:0]         sync2;
    logic [N-1:0]         clean;
    logic [N-1:0]         rise;
    logic [N-1:0]         fall;
    logic [N-1:0][CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            clean <= '0;
            rise  <= '0;
            fall  <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= bus.btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < N; i++) begin
                // Any agreeing sample restarts the stability window.
                if (sync2[i] == clean[i]) begin
                    cnt[i]  <= '0;
                    rise[i] <= 1'b0;
                    fall[i] <= 1'b0;
                end else if (cnt[i] != LAST) begin
                    cnt[i]  <= cnt[i] + CW'(1);
                    rise[i] <= 1'b0;
                    fall[i] <= 1'b0;
                end else begin
                    clean[i] <= sync2[i];
                    cnt[i]   <= '0;
                    rise[i]  <= sync2[i];
                    fall[i]  <= ~sync2[i];
                end
            end
        end
    end

    assign bus.btn_clean = clean;
    assign bus.btn_rise  = rise;
    assign bus.btn_fall  = fall;
endmodule

// File: tb/tb_input_debounce.sv
// Randomized and directed bench for input_debounce against a queue-based reference model.
module tb_input_debounce;
  localparam int N  = 2;
  localparam int SC = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  input_debounce_if #(.N(N)) bus ();
  input_debounce #(.N(N), .STABLE_CYCLES(SC)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  logic gate;
  assign gate = bus.btn_clean[0] & bus.btn_clean[1];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: exp_q holds raw samples still in flight through the synchronizer
  logic [N-1:0] exp_q[$];
  logic [N-1:0] m_clean = '0;
  logic [N-1:0] m_rise  = '0;
  logic [N-1:0] m_fall  = '0;
  int           run [N];
  int           rise_cnt [N];
  int           fall_cnt [N];

  always @(posedge clk) begin
    logic [N-1:0] s2;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back('0);
      exp_q.push_back('0);
      m_clean = '0;
      m_rise  = '0;
      m_fall  = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      s2 = exp_q.pop_front();
      exp_q.push_back(bus.btn_raw);
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < N; i++) begin
        run[i] = (s2[i] != m_clean[i]) ? run[i] + 1 : 0;
        if (run[i] == SC) begin
          m_clean[i] = s2[i];
          m_rise[i]  = s2[i];
          m_fall[i]  = ~s2[i];
          run[i]     = 0;
        end
      end
    end
  end

  // compare process, away from the active edge
  always @(negedge clk) begin
    check("clean", 32'(bus.btn_clean), 32'(m_clean));
    check("rise", 32'(bus.btn_rise), 32'(m_rise));
    check("fall", 32'(bus.btn_fall), 32'(m_fall));
    check("rise_and_fall", 32'(bus.btn_rise & bus.btn_fall), 32'd0);
    check("gate", 32'(gate), 32'(m_clean[0] & m_clean[1]));
    for (int i = 0; i < N; i++) begin
      if (bus.btn_rise[i] === 1'b1) rise_cnt[i]++;
      if (bus.btn_fall[i] === 1'b1) fall_cnt[i]++;
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [N-1:0] v);
    bus.btn_raw = v;
  endtask

  initial begin
    int r0, f0, r1, f1;
    logic [1:0] combo;
    for (int i = 0; i < N; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end

    // reset values, raw held high
    drive(2'b11);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_clean", 32'(bus.btn_clean), 32'd0);
      check("rst_rise", 32'(bus.btn_rise), 32'd0);
      check("rst_fall", 32'(bus.btn_fall), 32'd0);
    end
    rst = 1'b0;
    tick(5);
    check("post_rst_clean_e4", 32'(bus.btn_clean), 32'd0);
    tick();
    check("post_rst_clean_e5", 32'(bus.btn_clean), 32'b11);
    check("post_rst_rise_e5", 32'(bus.btn_rise), 32'b11);
    tick();
    check("post_rst_rise_gone", 32'(bus.btn_rise), 32'd0);

    // return to idle, then clean press/release on ch0
    drive(2'b00);
    tick(12);
    r0 = rise_cnt[0]; f0 = fall_cnt[0]; r1 = rise_cnt[1]; f1 = fall_cnt[1];
    drive(2'b01);
    tick(5);
    check("press_clean_e4", 32'(bus.btn_clean), 32'b00);
    tick();
    check("press_clean_e5", 32'(bus.btn_clean), 32'b01);
    check("press_rise_e5", 32'(bus.btn_rise), 32'b01);
    tick(14);
    drive(2'b00);
    tick(5);
    check("release_clean_e4", 32'(bus.btn_clean), 32'b01);
    tick();
    check("release_clean_e5", 32'(bus.btn_clean), 32'b00);
    check("release_fall_e5", 32'(bus.btn_fall), 32'b01);
    tick(4);
    check("press_rise_count", 32'(rise_cnt[0] - r0), 32'd1);
    check("press_fall_count", 32'(fall_cnt[0] - f0), 32'd1);
    check("ch1_quiet", 32'((rise_cnt[1] - r1) + (fall_cnt[1] - f1)), 32'd0);

    // bounce rejection on ch0
    r0 = rise_cnt[0];
    foreach (combo[j]) ;
    begin
      logic [5:0] seq;
      seq = 6'b101101;
      for (int k = 5; k >= 0; k--) begin
        drive({1'b0, seq[k]});
        tick();
        check("bounce_hold", 32'(bus.btn_clean), 32'b00);
      end
    end
    drive(2'b01);
    tick(12);
    check("bounce_clean", 32'(bus.btn_clean), 32'b01);
    check("bounce_rise_count", 32'(rise_cnt[0] - r0), 32'd1);

    // short glitch on ch1, then a full press proves the counter restarted
    r1 = rise_cnt[1];
    drive(2'b11);
    tick(3);
    drive(2'b01);
    tick(10);
    check("glitch_clean", 32'(bus.btn_clean), 32'b01);
    check("glitch_pulses", 32'(rise_cnt[1] - r1), 32'd0);
    drive(2'b11);
    tick(5);
    check("after_glitch_e4", 32'(bus.btn_clean[1]), 32'd0);
    tick();
    check("after_glitch_e5", 32'(bus.btn_clean[1]), 32'd1);

    // reset mid-operation with ch0 high
    drive(2'b01);
    tick(10);
    check("pre_rst_clean", 32'(bus.btn_clean), 32'b01);
    f0 = fall_cnt[0];
    rst = 1'b1;
    tick();
    check("mid_rst_clean", 32'(bus.btn_clean), 32'd0);
    check("mid_rst_fall", 32'(bus.btn_fall), 32'd0);
    rst = 1'b0;
    tick(5);
    check("rerise_e4", 32'(bus.btn_rise), 32'd0);
    tick();
    check("rerise_e5", 32'(bus.btn_rise), 32'b01);
    check("mid_rst_no_fall", 32'(fall_cnt[0] - f0), 32'd0);

    // downstream AND gate with bounce before each combination
    for (int c = 0; c < 4; c++) begin
      combo = 2'(c);
      for (int k = 0; k < 3; k++) begin
        drive(2'($urandom_range(0, 3)));
        tick();
      end
      drive(combo);
      tick(12);
      check("and_gate", 32'(gate), 32'(combo[0] & combo[1]));
    end

    // randomized segments
    for (int s = 0; s < 300; s++) begin
      drive(2'($urandom_range(0, 3)));
      tick($urandom_range(1, 7));
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
